// File: rtl/fb_scheduler_if.sv
// ---------------------------------------------------------------------------
// fb_scheduler_if
//   Bundles every non-clock signal of the framebuffer scheduler.
//   slave  modport : the scheduler itself.
//   master modport : the surrounding system (rasterizer, host, framebuffer
//                    memory, display), which drives the scheduler inputs.
//   Groups:
//     draw_*   : rasterizer pixel stream (valid/ready handshake)
//     clear_*  : clear request, fill colour, busy flag and done pulse
//     pixel_*  : framebuffer write port
//     read_*   : framebuffer read port (data returns one cycle later)
//     scan_*   : display pixel stream
//     drop_cnt : count of out-of-range draw beats
// ---------------------------------------------------------------------------
interface fb_scheduler_if;
   logic        draw_valid;
   logic        draw_ready;
   logic [7:0]  draw_x;
   logic [7:0]  draw_y;
   logic [23:0] draw_color;

   logic        clear_start;
   logic [23:0] clear_color;
   logic        clear_busy;
   logic        clear_done;

   logic        pixel_valid;
   logic [7:0]  pixel_x;
   logic [7:0]  pixel_y;
   logic [23:0] pixel_color;

   logic        read_en;
   logic [7:0]  read_x;
   logic [7:0]  read_y;
   logic [23:0] read_color;

   logic        scan_en;
   logic        scan_valid;
   logic [7:0]  scan_x;
   logic [7:0]  scan_y;
   logic [23:0] scan_color;
   logic        scan_sof;

   logic [15:0] drop_cnt;

   modport slave (
      input  draw_valid, draw_x, draw_y, draw_color,
      input  clear_start, clear_color,
      input  read_color, scan_en,
      output draw_ready, clear_busy, clear_done,
      output pixel_valid, pixel_x, pixel_y, pixel_color,
      output read_en, read_x, read_y,
      output scan_valid, scan_x, scan_y, scan_color, scan_sof,
      output drop_cnt
   );

   modport master (
      output draw_valid, draw_x, draw_y, draw_color,
      output clear_start, clear_color,
      output read_color, scan_en,
      input  draw_ready, clear_busy, clear_done,
      input  pixel_valid, pixel_x, pixel_y, pixel_color,
      input  read_en, read_x, read_y,
      input  scan_valid, scan_x, scan_y, scan_color, scan_sof,
      input  drop_cnt
   );
endinterface

// File: rtl/fb_scheduler.sv
// ---------------------------------------------------------------------------
// fb_scheduler
//   Framebuffer write scheduler. Merges the rasterizer pixel stream and a
//   full-screen clear onto a single framebuffer write port, and (optionally)
//   runs an independent raster scanout on the framebuffer read port.
//
//   Parameters : MAX_X, MAX_Y - last valid column/row (clear, scanout,
//                draw range check).
//   Ports      : clk - sole clock, rising edge
//                rst - asynchronous, active-high reset
//                bus - fb_scheduler_if.slave (draw, clear, pixel write,
//                      framebuffer read, scanout, drop counter)
//
//   Build option: define FB_SCANOUT_EN to include the scanout engine;
//   without it the read_* and scan_* outputs are tied low and scan_en /
//   read_color are ignored.
// ---------------------------------------------------------------------------
module fb_scheduler #(
   parameter int MAX_X = 255,
   parameter int MAX_Y = 255
) (
   input  logic           clk,
   input  logic           rst,
   fb_scheduler_if.slave  bus
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam logic [7:0] LAST_X = 8'(MAX_X);
   localparam logic [7:0] LAST_Y = 8'(MAX_Y);
   // Range limits one bit wider than the coordinates so the compare stays
   // meaningful even when the limit is the full 8-bit range.
   localparam logic [8:0] LIM_X  = 9'(MAX_X);
   localparam logic [8:0] LIM_Y  = 9'(MAX_Y);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [0:0]  state_q, state_d;
   logic [7:0]  cx_q, cx_d;
   logic [7:0]  cy_q, cy_d;
   logic        tail_q, tail_d;
   logic [23:0] ccol_q, ccol_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        pv_q, pv_d;
   logic [7:0]  px_q, px_d;
   logic [7:0]  py_q, py_d;
   logic [23:0] pc_q, pc_d;
   logic [15:0] drop_q, drop_d;

   logic        accept;
   logic        in_range;

   assign accept   = bus.draw_valid & ready_q;
   assign in_range = ({1'b0, bus.draw_x} <= LIM_X) && ({1'b0, bus.draw_y} <= LIM_Y);

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      tail_d  = tail_q;
      ccol_d  = ccol_q;
      done_d  = 1'b0;
      pv_d    = 1'b0;
      px_d    = px_q;
      py_d    = py_q;
      pc_d    = pc_q;
      drop_d  = drop_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_range) begin
                  pv_d = 1'b1;
                  px_d = bus.draw_x;
                  py_d = bus.draw_y;
                  pc_d = bus.draw_color;
               end else begin
                  drop_d = sat_inc16(drop_q);
               end
            end
            // A coincident draw beat is written this cycle; the first clear
            // write follows on the next one.
            if (bus.clear_start) begin
               state_d = ST_CLEAR;
               cx_d    = 8'd0;
               cy_d    = 8'd0;
               tail_d  = 1'b0;
               ccol_d  = bus.clear_color;
            end
         end
         ST_CLEAR: begin
            // tail_q marks the cycle in which the final write is on the
            // write port; the FSM leaves CLEAR on the following edge.
            if (!tail_q) begin
               pv_d = 1'b1;
               px_d = cx_q;
               py_d = cy_q;
               pc_d = ccol_q;
               if (cx_q == LAST_X) begin
                  cx_d = 8'd0;
                  if (cy_q == LAST_Y) begin
                     tail_d = 1'b1;
                  end else begin
                     cy_d = cy_q + 8'd1;
                  end
               end else begin
                  cx_d = cx_q + 8'd1;
               end
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               tail_d  = 1'b0;
               cx_d    = 8'd0;
               cy_d    = 8'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cx_q    <= 8'd0;
         cy_q    <= 8'd0;
         tail_q  <= 1'b0;
         ccol_q  <= 24'd0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         pv_q    <= 1'b0;
         px_q    <= 8'd0;
         py_q    <= 8'd0;
         pc_q    <= 24'd0;
         drop_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         tail_q  <= tail_d;
         ccol_q  <= ccol_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         pv_q    <= pv_d;
         px_q    <= px_d;
         py_q    <= py_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.draw_ready  = ready_q;
   assign bus.clear_busy  = (state_q == ST_CLEAR);
   assign bus.clear_done  = done_q;
   assign bus.pixel_valid = pv_q;
   assign bus.pixel_x     = px_q;
   assign bus.pixel_y     = py_q;
   assign bus.pixel_color = pc_q;
   assign bus.drop_cnt    = drop_q;

`ifdef FB_SCANOUT_EN
   logic [7:0] rx_q, rx_d;
   logic [7:0] ry_q, ry_d;
   logic [7:0] sx_q, sx_d;
   logic [7:0] sy_q, sy_d;
   logic       sv_q, sv_d;
   logic       sof_q, sof_d;
   logic       rd_en;

   // Read request is combinational on scan_en so the first address goes out
   // in the same cycle scanout is enabled; gated so it is low during reset.
   assign rd_en = bus.scan_en & ~rst;

   always_comb begin
      rx_d = 8'd0;
      ry_d = 8'd0;
      if (rd_en) begin
         if (rx_q == LAST_X) begin
            rx_d = 8'd0;
            ry_d = (ry_q == LAST_Y) ? 8'd0 : ry_q + 8'd1;
         end else begin
            rx_d = rx_q + 8'd1;
            ry_d = ry_q;
         end
      end
      // Sample descriptor travels one cycle behind its read request,
      // aligned with read_color returning from the framebuffer.
      sv_d  = rd_en;
      sx_d  = rx_q;
      sy_d  = ry_q;
      sof_d = rd_en && (rx_q == 8'd0) && (ry_q == 8'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q  <= 8'd0;
         ry_q  <= 8'd0;
         sx_q  <= 8'd0;
         sy_q  <= 8'd0;
         sv_q  <= 1'b0;
         sof_q <= 1'b0;
      end else begin
         rx_q  <= rx_d;
         ry_q  <= ry_d;
         sx_q  <= sx_d;
         sy_q  <= sy_d;
         sv_q  <= sv_d;
         sof_q <= sof_d;
      end
   end

   assign bus.read_en    = rd_en;
   assign bus.read_x     = rx_q;
   assign bus.read_y     = ry_q;
   assign bus.scan_valid = sv_q;
   assign bus.scan_x     = sx_q;
   assign bus.scan_y     = sy_q;
   assign bus.scan_color = sv_q ? bus.read_color : 24'd0;
   assign bus.scan_sof   = sof_q;
`else
   logic unused_scan;
   assign unused_scan = ^{bus.scan_en, bus.read_color};

   assign bus.read_en    = 1'b0;
   assign bus.read_x     = 8'd0;
   assign bus.read_y     = 8'd0;
   assign bus.scan_valid = 1'b0;
   assign bus.scan_x     = 8'd0;
   assign bus.scan_y     = 8'd0;
   assign bus.scan_color = 24'd0;
   assign bus.scan_sof   = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fb_scheduler
//   Bench for fb_scheduler. A small instance (MAX_X=3, MAX_Y=1) carries the
//   draw/clear/scanout/reset scenarios; a default-size instance shares the
//   draw inputs so a full-range coordinate beat can be observed.
// ---------------------------------------------------------------------------
module tb_fb_scheduler;
   localparam int MX   = 3;
   localparam int MY   = 1;
   localparam int NPIX = (MX + 1) * (MY + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fb_scheduler_if ifc();
   fb_scheduler_if ifd();

   fb_scheduler #(.MAX_X(MX), .MAX_Y(MY)) dut (.clk(clk), .rst(rst), .bus(ifc));
   fb_scheduler dut_big (.clk(clk), .rst(rst), .bus(ifd));

   assign ifd.draw_valid  = ifc.draw_valid;
   assign ifd.draw_x      = ifc.draw_x;
   assign ifd.draw_y      = ifc.draw_y;
   assign ifd.draw_color  = ifc.draw_color;
   assign ifd.clear_start = 1'b0;
   assign ifd.clear_color = 24'd0;
   assign ifd.scan_en     = 1'b0;
   assign ifd.read_color  = 24'd0;

   // Framebuffer memory model: colour is a function of the requested address.
   logic [23:0] mem_q;
   always @(posedge clk) mem_q <= {8'hA5, ifc.read_x, ifc.read_y};
   assign ifc.read_color = mem_q;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_drop = 0;

   logic [39:0] pix_q[$];
   logic [40:0] scan_q[$];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_clear(input logic [23:0] col);
      for (int y = 0; y <= MY; y++)
         for (int x = 0; x <= MX; x++)
            pix_q.push_back({8'(x), 8'(y), col});
   endtask

   task automatic set_beat(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
      ifc.draw_valid = v;
      ifc.draw_x     = x;
      ifc.draw_y     = y;
      ifc.draw_color = c;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 40 && !ifc.clear_done; k++) cyc();
      check_eq(tag, 64'(ifc.clear_done), 64'd1);
   endtask

   // Write-port scoreboard
   always @(negedge clk) begin
      if (!rst && ifc.pixel_valid) begin
         if (pix_q.size() == 0) begin
            check_eq("pix_unexpected", 64'(pix_q.size()), 64'd1);
         end else begin
            logic [39:0] e;
            e = pix_q.pop_front();
            check_eq("pix", 64'({ifc.pixel_x, ifc.pixel_y, ifc.pixel_color}), 64'(e));
         end
      end
   end

`ifdef FB_SCANOUT_EN
   // Scanout scoreboard
   always @(negedge clk) begin
      if (!rst && ifc.scan_valid) begin
         if (scan_q.size() == 0) begin
            check_eq("scan_unexpected", 64'(scan_q.size()), 64'd1);
         end else begin
            logic [40:0] e;
            e = scan_q.pop_front();
            check_eq("scan", 64'({ifc.scan_sof, ifc.scan_x, ifc.scan_y, ifc.scan_color}), 64'(e));
         end
      end
   end
`endif

   initial begin
      logic [7:0]  bx, by;
      logic [23:0] bc;
      logic        bv;

      set_beat(1'b0, 8'd0, 8'd0, 24'd0);
      ifc.clear_start = 1'b0;
      ifc.clear_color = 24'd0;
      ifc.scan_en     = 1'b0;

      // Reset state
      #2 rst = 1'b1;
      repeat (3) cyc();
      check_eq("rst_ready",  64'(ifc.draw_ready), 64'd0);
      check_eq("rst_pixel",  64'({ifc.pixel_valid, ifc.pixel_x, ifc.pixel_y, ifc.pixel_color}), 64'd0);
      check_eq("rst_clear",  64'({ifc.clear_busy, ifc.clear_done}), 64'd0);
      check_eq("rst_drop",   64'(ifc.drop_cnt), 64'd0);
      check_eq("rst_scan",   64'({ifc.read_en, ifc.read_x, ifc.read_y, ifc.scan_valid, ifc.scan_sof}), 64'd0);
      check_eq("rst_big_rdy", 64'(ifd.draw_ready), 64'd0);
      rst = 1'b0;
      cyc();
      check_eq("ready_after_rst", 64'(ifc.draw_ready), 64'd1);
      check_eq("big_ready_after_rst", 64'(ifd.draw_ready), 64'd1);

      // Full-range beat: written by the default instance, dropped by the small one
      set_beat(1'b1, 8'd10, 8'd20, 24'hFF0000);
      exp_drop++;
      cyc();
      set_beat(1'b0, 8'd0, 8'd0, 24'd0);
      check_eq("big_pix_valid", 64'(ifd.pixel_valid), 64'd1);
      check_eq("big_pix_data", 64'({ifd.pixel_x, ifd.pixel_y, ifd.pixel_color}), 64'({8'd10, 8'd20, 24'hFF0000}));
      check_eq("drop_full_range", 64'(ifc.drop_cnt), 64'(exp_drop));
      cyc();
      check_eq("big_pix_idle", 64'({ifd.pixel_valid, ifd.pixel_x}), 64'({1'b0, 8'd10}));

      // x just past the edge is dropped, x on the edge is written
      set_beat(1'b1, 8'd4, 8'd0, 24'h111111);
      exp_drop++;
      cyc();
      set_beat(1'b1, 8'd3, 8'd1, 24'hABCDEF);
      pix_q.push_back({8'd3, 8'd1, 24'hABCDEF});
      cyc();
      set_beat(1'b0, 8'd0, 8'd0, 24'd0);
      check_eq("drop_edge", 64'(ifc.drop_cnt), 64'(exp_drop));

      // Random draw traffic with gaps and out-of-range coordinates
      for (int i = 0; i < 24; i++) begin
         bv = ($urandom_range(0, 3) != 0);
         bx = 8'($urandom_range(0, 5));
         by = 8'($urandom_range(0, 2));
         bc = 24'($urandom);
         set_beat(bv, bx, by, bc);
         if (bv) begin
            if (bx <= 8'(MX) && by <= 8'(MY)) pix_q.push_back({bx, by, bc});
            else exp_drop++;
         end
         cyc();
      end
      set_beat(1'b0, 8'd0, 8'd0, 24'd0);
      cyc();
      check_eq("drop_random", 64'(ifc.drop_cnt), 64'(exp_drop));
      check_eq("pix_idle", 64'(ifc.pixel_valid), 64'd0);

      // Clear: junk beats and a repeated clear_start while busy must be ignored
      ifc.clear_color = 24'h00FF00;
      ifc.clear_start = 1'b1;
      push_clear(24'h00FF00);
      cyc();
      ifc.clear_start = 1'b0;
      ifc.clear_color = 24'hDEAD00;
      check_eq("clr_first", 64'({ifc.clear_busy, ifc.draw_ready, ifc.pixel_valid, ifc.clear_done}), 64'(4'b1000));
      for (int k = 0; k < NPIX; k++) begin
         set_beat(k < NPIX - 1, 8'd0, 8'd0, 24'h777777);
         ifc.clear_start = (k == 2);
         cyc();
         check_eq("clr_run", 64'({ifc.clear_busy, ifc.draw_ready, ifc.pixel_valid, ifc.clear_done}), 64'(4'b1010));
      end
      set_beat(1'b0, 8'd0, 8'd0, 24'd0);
      ifc.clear_start = 1'b0;
      cyc();
      check_eq("clr_done", 64'({ifc.clear_busy, ifc.draw_ready, ifc.pixel_valid, ifc.clear_done}), 64'(4'b0101));
      cyc();
      check_eq("clr_done_pulse", 64'(ifc.clear_done), 64'd0);

      // Draw beat coincident with clear_start: beat first, then the clear
      set_beat(1'b1, 8'd1, 8'd1, 24'h123456);
      ifc.clear_color = 24'h0000FF;
      ifc.clear_start = 1'b1;
      pix_q.push_back({8'd1, 8'd1, 24'h123456});
      push_clear(24'h0000FF);
      cyc();
      set_beat(1'b0, 8'd0, 8'd0, 24'd0);
      ifc.clear_start = 1'b0;
      check_eq("co_first", 64'({ifc.pixel_valid, ifc.clear_busy, ifc.draw_ready}), 64'(3'b110));
      wait_done("co_done");
      cyc();

      // Scanout
`ifdef FB_SCANOUT_EN
      begin
         int mx, my;
         mx = 0;
         my = 0;
         ifc.scan_en = 1'b1;
         for (int i = 0; i < 12; i++) begin
            #1;
            check_eq("scan_req", 64'({ifc.read_en, ifc.read_x, ifc.read_y}), 64'({1'b1, 8'(mx), 8'(my)}));
            scan_q.push_back({(mx == 0 && my == 0), 8'(mx), 8'(my), 8'hA5, 8'(mx), 8'(my)});
            if (mx == MX) begin
               mx = 0;
               my = (my == MY) ? 0 : my + 1;
            end else begin
               mx++;
            end
            cyc();
         end
         ifc.scan_en = 1'b0;
         #1;
         check_eq("scan_off_req", 64'(ifc.read_en), 64'd0);
         cyc();
         cyc();
         check_eq("scan_off", 64'({ifc.scan_valid, ifc.read_x, ifc.read_y}), 64'd0);
         ifc.scan_en = 1'b1;
         #1;
         check_eq("scan_restart", 64'({ifc.read_en, ifc.read_x, ifc.read_y}), 64'({1'b1, 16'd0}));
         scan_q.push_back({1'b1, 8'd0, 8'd0, 8'hA5, 8'd0, 8'd0});
         cyc();
         ifc.scan_en = 1'b0;
         cyc();
         cyc();
         check_eq("scan_empty", 64'(scan_q.size()), 64'd0);
      end
`else
      ifc.scan_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_eq("scan_tied", 64'({ifc.read_en, ifc.read_x, ifc.read_y, ifc.scan_valid, ifc.scan_sof}), 64'd0);
         check_eq("scan_tied_xyc", 64'({ifc.scan_x, ifc.scan_y, ifc.scan_color}), 64'd0);
      end
      ifc.scan_en = 1'b0;
      cyc();
`endif

      // Reset in the middle of a clear
      ifc.clear_color = 24'h00FF00;
      ifc.clear_start = 1'b1;
      push_clear(24'h00FF00);
      cyc();
      ifc.clear_start = 1'b0;
      cyc();
      cyc();
      cyc();
      check_eq("mid_clear_pos", 64'({ifc.pixel_valid, ifc.pixel_x, ifc.pixel_y}), 64'({1'b1, 8'd2, 8'd0}));
      rst = 1'b1;
      pix_q.delete();
      #1;
      check_eq("rst_mid_out", 64'({ifc.draw_ready, ifc.pixel_valid, ifc.pixel_x, ifc.pixel_y, ifc.clear_busy, ifc.clear_done, ifc.drop_cnt}), 64'd0);
      check_eq("rst_mid_color", 64'(ifc.pixel_color), 64'd0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         check_eq("rst_no_done", 64'(ifc.clear_done), 64'd0);
      end
      rst = 1'b0;
      exp_drop = 0;
      cyc();
      check_eq("ready_after_mid_rst", 64'({ifc.draw_ready, ifc.clear_busy}), 64'(2'b10));
      ifc.clear_color = 24'hC0FFEE;
      ifc.clear_start = 1'b1;
      push_clear(24'hC0FFEE);
      cyc();
      ifc.clear_start = 1'b0;
      wait_done("restart_done");
      cyc();

      // Drop counter saturation
      set_beat(1'b1, 8'd7, 8'd0, 24'h0);
      for (int i = 0; i < 65540; i++) begin
         if (exp_drop < 65535) exp_drop++;
         cyc();
      end
      set_beat(1'b0, 8'd0, 8'd0, 24'd0);
      cyc();
      check_eq("drop_sat", 64'(ifc.drop_cnt), 64'(exp_drop));

      repeat (3) cyc();
      check_eq("sb_empty", 64'(pix_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
